// File: rtl/alu_ctrl_pkg.sv
// Shared constants and FSM state type for the ALU control sequencer.
// Mult/div support is enabled by defining ALU_CTRL_MULDIV_EN.
package alu_ctrl_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_RTYPE   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;

  localparam logic [3:0] CS_AND  = 4'b0000;
  localparam logic [3:0] CS_OR   = 4'b0001;
  localparam logic [3:0] CS_ADD  = 4'b0010;
  localparam logic [3:0] CS_SUB  = 4'b0110;
  localparam logic [3:0] CS_SLT  = 4'b0111;
  localparam logic [3:0] CS_NOR  = 4'b1100;
  localparam logic [3:0] CS_MULT = 4'b1000;
  localparam logic [3:0] CS_DIV  = 4'b1001;

  typedef enum logic [1:0] {IDLE, MULDIV, DONE} state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between the main decoder (master) and the ALU
// control sequencer (slave).
interface alu_ctrl_seq_if #(
  parameter int FUNCT_W = 6,
  parameter int CS_W    = 4
);
  logic               valid_in;
  logic [1:0]         ALUop;
  logic [FUNCT_W-1:0] functCode;
  logic               ready;
  logic [CS_W-1:0]    aluCS;
  logic               ctrl_valid;
  logic               busy;
  logic               mdu_start;
  logic               mdu_div;
  logic               done;
  logic               err;

  modport master (
    output valid_in, ALUop, functCode,
    input  ready, aluCS, ctrl_valid, busy, mdu_start, mdu_div, done, err
  );

  modport slave (
    input  valid_in, ALUop, functCode,
    output ready, aluCS, ctrl_valid, busy, mdu_start, mdu_div, done, err
  );
endinterface

// File: rtl/mdu_seq_cnt.sv
// Down-counter timing a multi-cycle mult/div; tc flags the final busy cycle.
// Only instantiated when ALU_CTRL_MULDIV_EN is defined.
module mdu_seq_cnt #(
  parameter int CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(CYCLES - 1);
    end else if (en && cnt != '0) begin
      // Saturates at zero so a stray enable can never wrap the count.
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with registered aluCS and an optional mult/div sequencer.
// Define ALU_CTRL_MULDIV_EN to enable mult/div; otherwise those functs are illegal.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W       = 6,
  parameter int CS_W          = 4,
  parameter int MULDIV_CYCLES = 32
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_seq_if.slave bus
);

  if (MULDIV_CYCLES < 2 || MULDIV_CYCLES > 64) begin : g_bad_cycles
    $error("MULDIV_CYCLES must be in 2..64");
  end

  logic            ready;
  logic            accept;
  logic            dec_legal;
  logic [CS_W-1:0] dec_cs;
  logic [CS_W-1:0] alu_cs_q;
  logic            ctrl_valid_q;
  logic            err_q;
`ifdef ALU_CTRL_MULDIV_EN
  logic            dec_md;
  logic            dec_div;
`endif

  assign accept = bus.valid_in && ready;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    dec_legal = 1'b1;
    dec_cs    = CS_W'(CS_ADD);
`ifdef ALU_CTRL_MULDIV_EN
    dec_md    = 1'b0;
    dec_div   = 1'b0;
`endif
    case (bus.ALUop)
      OP_ADD: dec_cs = CS_W'(CS_ADD);
      OP_SUB: dec_cs = CS_W'(CS_SUB);
      OP_RTYPE: begin
        case (bus.functCode)
          FUNCT_W'(F_ADD): dec_cs = CS_W'(CS_ADD);
          FUNCT_W'(F_SUB): dec_cs = CS_W'(CS_SUB);
          FUNCT_W'(F_AND): dec_cs = CS_W'(CS_AND);
          FUNCT_W'(F_OR):  dec_cs = CS_W'(CS_OR);
          FUNCT_W'(F_NOR): dec_cs = CS_W'(CS_NOR);
          FUNCT_W'(F_SLT): dec_cs = CS_W'(CS_SLT);
`ifdef ALU_CTRL_MULDIV_EN
          FUNCT_W'(F_MULT): begin
            dec_cs = CS_W'(CS_MULT);
            dec_md = 1'b1;
          end
          FUNCT_W'(F_DIV): begin
            dec_cs  = CS_W'(CS_DIV);
            dec_md  = 1'b1;
            dec_div = 1'b1;
          end
`endif
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // NOTE: registered state is always written with non-blocking assignments to avoid simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cs_q     <= CS_W'(CS_ADD);
      ctrl_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ctrl_valid_q <= accept && dec_legal;
      err_q        <= accept && !dec_legal;
      if (accept && dec_legal) alu_cs_q <= dec_cs;
    end
  end

`ifdef ALU_CTRL_MULDIV_EN
  state_e state;
  state_e state_nx;
  logic   cnt_load;
  logic   cnt_tc;
  logic   mdu_start_q;
  logic   mdu_div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mdu_start_q <= 1'b0;
      mdu_div_q   <= 1'b0;
    end else begin
      state       <= state_nx;
      mdu_start_q <= cnt_load;
      mdu_div_q   <= cnt_load && dec_div;
    end
  end

  // DONE accepts like IDLE, which gives back-to-back issue after a mult/div.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept && dec_legal && dec_md) begin
          state_nx = MULDIV;
          cnt_load = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      MULDIV:  if (cnt_tc) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  mdu_seq_cnt #(.CYCLES(MULDIV_CYCLES)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .en   (state == MULDIV),
    .tc   (cnt_tc)
  );

  assign ready         = (state != MULDIV);
  assign bus.busy      = (state == MULDIV);
  assign bus.done      = (state == DONE);
  assign bus.mdu_start = mdu_start_q;
  assign bus.mdu_div   = mdu_div_q;
`else
  assign ready         = 1'b1;
  assign bus.busy      = 1'b0;
  assign bus.done      = 1'b0;
  assign bus.mdu_start = 1'b0;
  assign bus.mdu_div   = 1'b0;
`endif

  assign bus.ready      = ready;
  assign bus.aluCS      = alu_cs_q;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed cases plus randomized traffic
// compared every cycle against a cycle-count reference model.
module tb_alu_ctrl_seq;
  localparam int FUNCT_W = 6;
  localparam int CS_W    = 4;
  localparam int N       = 32;
`ifdef ALU_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.FUNCT_W(FUNCT_W), .CS_W(CS_W)) bus ();

  alu_ctrl_seq #(.FUNCT_W(FUNCT_W), .CS_W(CS_W), .MULDIV_CYCLES(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: kind 0 = illegal, 1 = single-cycle, 2 = mult, 3 = div.
  function automatic void ref_dec(input logic [1:0] op, input logic [5:0] f,
                                  output int kind, output logic [3:0] cs);
    kind = 0;
    cs   = 4'b0000;
    case (op)
      2'b00: begin kind = 1; cs = 4'b0010; end
      2'b01: begin kind = 1; cs = 4'b0110; end
      2'b10: begin
        case (f)
          6'b100000: begin kind = 1; cs = 4'b0010; end
          6'b100010: begin kind = 1; cs = 4'b0110; end
          6'b100100: begin kind = 1; cs = 4'b0000; end
          6'b100101: begin kind = 1; cs = 4'b0001; end
          6'b100111: begin kind = 1; cs = 4'b1100; end
          6'b101010: begin kind = 1; cs = 4'b0111; end
          6'b011000: if (MD_EN) begin kind = 2; cs = 4'b1000; end
          6'b011010: if (MD_EN) begin kind = 3; cs = 4'b1001; end
          default: kind = 0;
        endcase
      end
      default: kind = 0;
    endcase
  endfunction

  // Model: busy_left counts remaining busy cycles; requests only land when it is zero.
  logic [3:0] m_cs;
  logic       m_ctrl, m_err, m_start, m_div, m_done;
  int         m_busy_left;

  always @(posedge clk or negedge rst_n) begin : model
    int         kind;
    logic [3:0] cs;
    if (!rst_n) begin
      m_cs = 4'b0010; m_ctrl = 0; m_err = 0; m_start = 0; m_div = 0; m_done = 0;
      m_busy_left = 0;
    end else begin
      m_ctrl = 0; m_err = 0; m_start = 0; m_div = 0; m_done = 0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) m_done = 1;
      end else if (bus.valid_in) begin
        ref_dec(bus.ALUop, bus.functCode, kind, cs);
        if (kind == 0) begin
          m_err = 1;
        end else begin
          m_ctrl = 1;
          m_cs   = cs;
          if (kind >= 2) begin
            m_start     = 1;
            m_div       = (kind == 3);
            m_busy_left = N;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    check("aluCS",      32'(bus.aluCS),      32'(m_cs));
    check("ctrl_valid", 32'(bus.ctrl_valid), 32'(m_ctrl));
    check("err",        32'(bus.err),        32'(m_err));
    check("ready",      32'(bus.ready),      32'(m_busy_left == 0));
    check("busy",       32'(bus.busy),       32'(m_busy_left > 0));
    check("mdu_start",  32'(bus.mdu_start),  32'(m_start));
    check("mdu_div",    32'(bus.mdu_div),    32'(m_div));
    check("done",       32'(bus.done),       32'(m_done));
  end

  task automatic step(input logic v, input logic [1:0] op, input logic [5:0] f);
    bus.valid_in  = v;
    bus.ALUop     = op;
    bus.functCode = f;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_aluCS"}, 32'(bus.aluCS),      32'h2);
    check({tag, "_cv"},    32'(bus.ctrl_valid), 32'h0);
    check({tag, "_err"},   32'(bus.err),        32'h0);
    check({tag, "_ready"}, 32'(bus.ready),      32'h1);
    check({tag, "_busy"},  32'(bus.busy),       32'h0);
    check({tag, "_start"}, 32'(bus.mdu_start),  32'h0);
    check({tag, "_div"},   32'(bus.mdu_div),    32'h0);
    check({tag, "_done"},  32'(bus.done),       32'h0);
  endtask

  logic [5:0] fpool [10];

  initial begin
    fpool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
              6'b101010, 6'b011000, 6'b011010, 6'b000101, 6'b111111};
    bus.valid_in = 1'b0; bus.ALUop = 2'b00; bus.functCode = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Single-cycle ALUop decode with one-cycle latency.
    step(1'b1, 2'b00, 6'b0);
    check("add_cs", 32'(bus.aluCS), 32'h2);  check("add_cv", 32'(bus.ctrl_valid), 32'h1);
    step(1'b1, 2'b01, 6'b0);
    check("sub_cs", 32'(bus.aluCS), 32'h6);  check("sub_cv", 32'(bus.ctrl_valid), 32'h1);
    step(1'b0, 2'b00, 6'b0);
    check("hold_cs", 32'(bus.aluCS), 32'h6); check("hold_cv", 32'(bus.ctrl_valid), 32'h0);

    // Back-to-back R-type functs.
    step(1'b1, 2'b10, 6'b100100); check("and_cs", 32'(bus.aluCS), 32'h0); check("and_err", 32'(bus.err), 32'h0);
    step(1'b1, 2'b10, 6'b100101); check("or_cs",  32'(bus.aluCS), 32'h1);
    step(1'b1, 2'b10, 6'b100111); check("nor_cs", 32'(bus.aluCS), 32'hc);
    step(1'b1, 2'b10, 6'b101010); check("slt_cs", 32'(bus.aluCS), 32'h7); check("slt_err", 32'(bus.err), 32'h0);

    // Illegal ops leave aluCS alone.
    step(1'b1, 2'b01, 6'b0);
    step(1'b1, 2'b11, 6'b0);
    check("ill11_err", 32'(bus.err), 32'h1); check("ill11_cs", 32'(bus.aluCS), 32'h6);
    check("ill11_cv", 32'(bus.ctrl_valid), 32'h0);
    step(1'b1, 2'b10, 6'b000101);
    check("illf_err", 32'(bus.err), 32'h1);  check("illf_cs", 32'(bus.aluCS), 32'h6);
    step(1'b0, 2'b00, 6'b0);
    check("ill_clr", 32'(bus.err), 32'h0);

`ifdef ALU_CTRL_MULDIV_EN
    begin : mult_case
      int n = 1;
      step(1'b1, 2'b10, 6'b011000);
      check("mult_start", 32'(bus.mdu_start), 32'h1); check("mult_div", 32'(bus.mdu_div), 32'h0);
      check("mult_cs", 32'(bus.aluCS), 32'h8);        check("mult_busy", 32'(bus.busy), 32'h1);
      bus.ALUop = 2'b00;  // add held during busy
      for (int i = 0; i < 100 && bus.busy; i++) begin
        @(negedge clk);
        if (bus.busy) n++;
      end
      check("busy_len", 32'(n), 32'(N));
      check("done_pulse", 32'(bus.done), 32'h1);  check("done_ready", 32'(bus.ready), 32'h1);
      check("held_not_yet", 32'(bus.ctrl_valid), 32'h0);
      step(1'b0, 2'b00, 6'b0);
      check("held_cv", 32'(bus.ctrl_valid), 32'h1); check("held_cs", 32'(bus.aluCS), 32'h2);
      check("done_once", 32'(bus.done), 32'h0);
    end

    // Reset mid-divide at count 10.
    step(1'b1, 2'b10, 6'b011010);
    check("div_flag", 32'(bus.mdu_div), 32'h1);
    bus.valid_in = 1'b0;
    repeat (21) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("abort");
    @(negedge clk); check("abort_nodone", 32'(bus.done), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 2'b00, 6'b0);
    check("post_cs", 32'(bus.aluCS), 32'h2); check("post_cv", 32'(bus.ctrl_valid), 32'h1);
`else
    step(1'b1, 2'b10, 6'b011010);
    check("nodiv_err", 32'(bus.err), 32'h1);   check("nodiv_busy", 32'(bus.busy), 32'h0);
    check("nodiv_ready", 32'(bus.ready), 32'h1);
    step(1'b0, 2'b00, 6'b0);
    check("nodiv_ready2", 32'(bus.ready), 32'h1);
`endif

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rand_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b10,
           fpool[$urandom_range(0, 9)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter FUNCT_W, default 6: functCode width.
REQ-003 Parameter CS_W, default 4: aluCS width.
REQ-004 Parameter MULDIV_CYCLES, default 32: number of busy cycles for a mult/div op, range 2..64.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
- valid_in  in  1  ALUop/functCode valid this cycle.
- ALUop  in  2  main-decoder op class.
- functCode  in  FUNCT_W  R-type funct field.
- ready  out  1  request accepted when valid_in && ready.
- aluCS  out  CS_W  registered ALU control select.
- ctrl_valid  out  1  one-cycle pulse: aluCS is a newly decoded value.
- busy  out  1  multi-cycle op in progress (pipeline stall).
- mdu_start  out  1  one-cycle pulse to the multiply/divide unit.
- mdu_div  out  1  0 = mult, 1 = div; valid with mdu_start.
- done  out  1  one-cycle pulse: multi-cycle op complete.
- err  out  1  one-cycle pulse: illegal op accepted.

Function
REQ-006 Decode SHALL be: ALUop 00 -> 0010 (add); 01 -> 0110 (sub); 10 -> per funct; 11 -> illegal.
REQ-007 Funct decode SHALL be: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 100111 nor 1100; 101010 slt 0111; 011000 mult 1000; 011010 div 1001; any other funct -> illegal.
REQ-008 The FSM SHALL have states IDLE, MULDIV and DONE.
REQ-009 ready SHALL be 1 in IDLE and DONE, and 0 in MULDIV.
REQ-010 A single-cycle op accepted at edge k SHALL update aluCS and pulse ctrl_valid in the cycle after edge k (1-cycle latency); the FSM stays in IDLE.
REQ-011 An accepted mult/div SHALL, at the same edge:
- load aluCS and pulse ctrl_valid;
- pulse mdu_start and set mdu_div;
- load the counter with MULDIV_CYCLES-1;
- move the FSM to MULDIV.
REQ-012 In MULDIV, busy SHALL be 1 and the counter SHALL decrement each cycle; at count 0 the FSM moves to DONE, so busy is high for exactly MULDIV_CYCLES cycles.
REQ-013 In DONE, done SHALL pulse for one cycle and the FSM SHALL return to IDLE, unless a new request is accepted in that same cycle, in which case that request is processed as if from IDLE (back-to-back).
REQ-014 valid_in while ready=0 SHALL be ignored, with no state change; the upstream holds its request.
REQ-015 An accepted illegal op SHALL pulse err for one cycle, leave aluCS unchanged, and not pulse ctrl_valid.
REQ-016 aluCS SHALL hold its last value when no request is accepted.
REQ-017 The counter width SHALL be $clog2(MULDIV_CYCLES), and it SHALL never wrap below 0.

Reset
REQ-018 Asserting rst_n SHALL immediately force:
- FSM to IDLE, counter to 0, aluCS to 0010;
- ready to 1;
- ctrl_valid, busy, mdu_start, mdu_div, done and err to 0.
REQ-019 Reset during MULDIV SHALL abort the op with no done pulse; the first accepted request after reset deassertion behaves as from IDLE.

Configuration
REQ-020 With ALU_CTRL_MULDIV_EN defined, mult/div SHALL behave per REQ-011..013.
REQ-021 Without ALU_CTRL_MULDIV_EN, funct 011000 and 011010 SHALL be illegal (REQ-015); the MULDIV and DONE states and the counter are not compiled; busy, mdu_start, mdu_div and done are tied to 0; ready is tied to 1.

Structure
REQ-022 Package alu_ctrl_pkg SHALL hold the ALUop constants, funct constants, aluCS encodings and the FSM state typedef.
REQ-023 The counter and its terminal-count logic SHALL be a sub-module, mdu_seq_cnt, instantiated only when ALU_CTRL_MULDIV_EN is defined.

Verification
REQ-024 Reset, then ALUop=00, then 01, each with valid_in=1 -> aluCS=0010 then 0110, each with ctrl_valid pulsed one cycle after acceptance.
REQ-025 ALUop=10 with funct 100100, 100101, 100111, 101010 back-to-back -> aluCS = 0000, 0001, 1100, 0111 on consecutive cycles; err=0.
REQ-026 ALUop=10, funct=011000, MULDIV_CYCLES=32 -> mdu_start=1 and mdu_div=0 for 1 cycle, busy=1 for exactly 32 cycles, done pulse, ready=1 throughout DONE; a valid_in held during busy is accepted only in DONE.
REQ-027 ALUop=11, and ALUop=10 with funct=000101 -> err pulses each time; aluCS retains its prior value (0110).
REQ-028 Div accepted, rst_n asserted at count 10 -> all outputs at reset values immediately, no done pulse; after release, add -> aluCS=0010 with 1-cycle latency.
REQ-029 Build without ALU_CTRL_MULDIV_EN, funct=011010 -> err pulses, busy stays 0, ready stays 1.
